// File: rtl/mem_port_pkg.sv
// Shared encodings for the memory-port controller and the control FSM that drives it.
package mem_port_pkg;

    // Reusable default widths for the control FSM and the port controller.
    localparam int unsigned DefAddrW = 10;
    localparam int unsigned DefDataW = 16;

    // Width of the read-latency counter; enough for READ_LAT up to 4.
    localparam int unsigned LatCntW = 2;

    // Port controller sequencing states.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } state_e;

    // Operation captured at accept.
    typedef enum logic [1:0] {
        OpFetch = 2'd0,
        OpLoad  = 2'd1,
        OpStore = 2'd2
    } op_e;

endpackage

// File: rtl/mem_port_ctrl.sv
// Memory-port controller: accepts one fetch/load/store at a time, drives the single-port RAM
// for the configured read latency and returns the result with a one-cycle valid pulse.
module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int unsigned ADDR_W   = DefAddrW,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_fetch,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] rdest,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fetch,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The latency counter is only LatCntW bits wide, so reject anything it cannot hold.
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("mem_port_ctrl: READ_LAT must be in 1..4");
    end

    localparam logic [LatCntW-1:0] LatLoad = LatCntW'(READ_LAT - 1);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [LatCntW-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_fetch_q, rsp_fetch_d;
    logic [DATA_W-1:0]   instr_q, instr_d;

    // Next-state and datapath capture; inputs are only looked at on the accept edge.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_fetch_d = rsp_fetch_q;
        instr_d     = instr_q;

        unique case (state_q)
            StIdle: begin
                // req_ready is just (StIdle && rst_n); the flops are held in reset otherwise.
                if (req_valid) begin
                    state_d = StIssue;
                    addr_d  = req_fetch ? pc : rdest;
                    wdata_d = wdata;
                    if (req_fetch) begin
                        op_d = OpFetch;
                    end else if (req_write) begin
                        op_d = OpStore;
                    end else begin
                        op_d = OpLoad;
                    end
                end
            end
            StIssue: begin
                if (op_q == OpStore) begin
                    state_d     = StResp;
                    rsp_data_d  = '0;
                    rsp_fetch_d = 1'b0;
                end else begin
                    state_d = StWait;
                    cnt_d   = LatLoad;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d     = StResp;
                    rsp_data_d  = mem_rdata;
                    rsp_fetch_d = (op_q == OpFetch);
                    if (op_q == OpFetch) begin
                        instr_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            op_q        <= OpFetch;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_fetch_q <= 1'b0;
            instr_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fetch_q <= rsp_fetch_d;
            instr_q     <= instr_d;
        end
    end

    // Outputs are registers or state decodes only; mem_we falls with the async state reset.
    always_comb begin
        req_ready = (state_q == StIdle) && rst_n;
        rsp_valid = (state_q == StResp);
        mem_we    = (state_q == StIssue) && (op_q == OpStore);
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        rsp_data  = rsp_data_q;
        rsp_fetch = rsp_fetch_q;
        instr     = instr_q;
    end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench: two controllers (READ_LAT 1 and 3) with behavioural RAMs, driven in
// lockstep, responses checked against a scoreboard built from a shadow memory model.
module tb_mem_port_ctrl;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 16;
    localparam int L1 = 1;
    localparam int L3 = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          v1    = 1'b0;
    logic          v3    = 1'b0;
    logic          fetch = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] pc    = '0;
    logic [AW-1:0] rdest = '0;
    logic [DW-1:0] wdata = '0;

    logic          rdy1, rv1, rf1, mw1;
    logic [DW-1:0] rd1, ins1, mwd1, mrd1;
    logic [AW-1:0] ma1;
    logic          rdy3, rv3, rf3, mw3;
    logic [DW-1:0] rd3, ins3, mwd3, mrd3;
    logic [AW-1:0] ma3;

    always #5 clk = ~clk;

    mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(L1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_fetch(fetch),
        .req_write(write), .pc(pc), .rdest(rdest), .wdata(wdata), .rsp_valid(rv1),
        .rsp_data(rd1), .rsp_fetch(rf1), .instr(ins1), .mem_addr(ma1), .mem_we(mw1),
        .mem_wdata(mwd1), .mem_rdata(mrd1)
    );

    mem_port_ctrl #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(L3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_fetch(fetch),
        .req_write(write), .pc(pc), .rdest(rdest), .wdata(wdata), .rsp_valid(rv3),
        .rsp_data(rd3), .rsp_fetch(rf3), .instr(ins3), .mem_addr(ma3), .mem_we(mw3),
        .mem_wdata(mwd3), .mem_rdata(mrd3)
    );

    // Behavioural RAMs with 1- and 3-cycle read latency.
    logic [DW-1:0] ram1 [1024];
    logic [DW-1:0] ram3 [1024];
    logic [DW-1:0] model [1024];
    logic [DW-1:0] p3a, p3b;

    always @(posedge clk) begin
        if (mw1) ram1[ma1] <= mwd1;
        mrd1 <= ram1[ma1];
    end

    always @(posedge clk) begin
        if (mw3) ram3[ma3] <= mwd3;
        p3a  <= ram3[ma3];
        p3b  <= p3a;
        mrd3 <= p3b;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] data;
        logic          fetch;
        int            cyc;
    } exp_t;

    exp_t          q1[$];
    exp_t          q3[$];
    logic [DW-1:0] ei1 = '0;
    logic [DW-1:0] ei3 = '0;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rsp(input int which, input logic [DW-1:0] rd, input logic rf,
                             input logic [DW-1:0] ins);
        exp_t e;
        if (which == 1) begin
            chk("rsp1_pending", 32'(q1.size() > 0), 1);
            if (q1.size() == 0) return;
            e = q1.pop_front();
            if (e.fetch) ei1 = e.data;
            chk("rsp1_data", 32'(rd), 32'(e.data));
            chk("rsp1_fetch", 32'(rf), 32'(e.fetch));
            chk("rsp1_cycle", cyc, e.cyc);
            chk("rsp1_instr", 32'(ins), 32'(ei1));
        end else begin
            chk("rsp3_pending", 32'(q3.size() > 0), 1);
            if (q3.size() == 0) return;
            e = q3.pop_front();
            if (e.fetch) ei3 = e.data;
            chk("rsp3_data", 32'(rd), 32'(e.data));
            chk("rsp3_fetch", 32'(rf), 32'(e.fetch));
            chk("rsp3_cycle", cyc, e.cyc);
            chk("rsp3_instr", 32'(ins), 32'(ei3));
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rv1) check_rsp(1, rd1, rf1, ins1);
            if (rv3) check_rsp(3, rd3, rf3, ins3);
        end
    end

    // Issue one request to both DUTs; called at a negedge, returns at the next (cycle 1).
    task automatic issue(input logic f, input logic w, input logic [AW-1:0] a_pc,
                         input logic [AW-1:0] a_rd, input logic [DW-1:0] wd);
        exp_t          e;
        int            n;
        logic [AW-1:0] a;
        logic          st;
        n = 0;
        while (!(rdy1 && rdy3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("issue_ready", 32'(rdy1 && rdy3), 1);
        fetch = f; write = w; pc = a_pc; rdest = a_rd; wdata = wd;
        v1 = 1'b1; v3 = 1'b1;
        a  = f ? a_pc : a_rd;
        st = !f && w;
        e.fetch = f;
        e.data  = st ? '0 : model[a];
        e.cyc   = cyc + (st ? 2 : L1 + 2);
        q1.push_back(e);
        e.cyc   = cyc + (st ? 2 : L3 + 2);
        q3.push_back(e);
        if (st) model[a] = wd;
        @(negedge clk);
        v1 = 1'b0; v3 = 1'b0;
        // Scramble inputs: post-accept changes must have no effect.
        fetch = 1'($urandom); write = 1'($urandom);
        pc = AW'($urandom); rdest = AW'($urandom); wdata = DW'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q3.size() != 0 || !rdy1 || !rdy3) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_q1", q1.size(), 0);
        chk("drain_q3", q3.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic any_we;
        for (int i = 0; i < 1024; i++) begin
            model[i] = DW'(i * 37) ^ 16'h5A5A;
            ram1[i]  = model[i];
            ram3[i]  = model[i];
        end
        model[5] = 16'hA123; ram1[5] = 16'hA123; ram3[5] = 16'hA123;

        // Reset held for 3 cycles.
        repeat (3) @(negedge clk);
        chk("rst_ready1", 32'(rdy1), 0);
        chk("rst_ready3", 32'(rdy3), 0);
        chk("rst_rsp_valid", 32'(rv1), 0);
        chk("rst_rsp_data", 32'(rd1), 0);
        chk("rst_rsp_fetch", 32'(rf1), 0);
        chk("rst_instr", 32'(ins1), 0);
        chk("rst_mem_addr", 32'(ma1), 0);
        chk("rst_mem_we", 32'(mw1), 0);
        chk("rst_mem_wdata", 32'(mwd1), 0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready1", 32'(rdy1), 1);
        chk("post_rst_ready3", 32'(rdy3), 1);
        @(negedge clk);

        // Fetch from pc=0x005.
        issue(1'b1, 1'b0, 10'h005, 10'h100, 16'h0000);
        chk("fetch_mem_addr1", 32'(ma1), 32'h005);
        chk("fetch_mem_addr3", 32'(ma3), 32'h005);
        chk("fetch_mem_we", 32'(mw1), 0);
        drain();
        chk("fetch_instr1", 32'(ins1), 32'hA123);
        chk("fetch_instr3", 32'(ins3), 32'hA123);

        // Store to the top address, then load it back.
        issue(1'b0, 1'b1, 10'h000, 10'h3FF, 16'hBEEF);
        chk("store_we1_c1", 32'(mw1), 1);
        chk("store_we3_c1", 32'(mw3), 1);
        chk("store_addr", 32'(ma1), 32'h3FF);
        chk("store_wdata", 32'(mwd1), 32'hBEEF);
        @(negedge clk);
        chk("store_we1_c2", 32'(mw1), 0);
        chk("store_rv_c2", 32'(rv1), 1);
        drain();
        issue(1'b0, 1'b0, 10'h005, 10'h3FF, 16'h0000);
        drain();
        chk("load_instr_kept", 32'(ins1), 32'hA123);

        // Latency-3 load with req_valid pulsed while busy.
        issue(1'b0, 1'b0, 10'h000, 10'h123, 16'h0000);
        v3 = 1'b1; fetch = 1'b0; write = 1'b1; rdest = 10'h0AA; wdata = 16'hFFFF;
        any_we = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("lat3_busy_ready", 32'(rdy3), 0);
            any_we |= mw3;
            @(negedge clk);
        end
        v3 = 1'b0;
        chk("lat3_ready_c6", 32'(rdy3), 1);
        chk("lat3_no_we", 32'(any_we), 0);
        drain();
        issue(1'b0, 1'b0, 10'h000, 10'h0AA, 16'h0000);
        drain();

        // Fetch with req_write set and rdest != pc: must read pc, never write.
        issue(1'b1, 1'b1, 10'h007, 10'h020, 16'hDEAD);
        any_we = mw1 | mw3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            any_we |= mw1 | mw3;
        end
        chk("fetch_wr_no_we", 32'(any_we), 0);
        drain();
        chk("fetch_wr_instr", 32'(ins1), 32'(model[7]));

        // Mixed random traffic, including back-to-back stores.
        for (int i = 0; i < 10; i++) begin
            issue(1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom), DW'($urandom));
        end
        drain();

        // Reset during ISSUE of a store.
        v1 = 1'b1; v3 = 1'b1; fetch = 1'b0; write = 1'b1; rdest = 10'h010; wdata = 16'h1234;
        @(negedge clk);
        v1 = 1'b0; v3 = 1'b0;
        chk("midrst_we_before", 32'(mw1), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we1_async", 32'(mw1), 0);
        chk("midrst_we3_async", 32'(mw3), 0);
        chk("midrst_instr1", 32'(ins1), 0);
        chk("midrst_instr3", 32'(ins3), 0);
        ei1 = '0; ei3 = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 1'b0, 10'h000, 10'h010, 16'h0000);
        drain();
        chk("midrst_instr_after", 32'(ins1), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Memory-port controller between the control FSM and the single-port block RAM. It accepts one request at a time: an instruction fetch addressed by `pc`, or a data load/store addressed by `rdest`. It registers the selected address and write data, drives the RAM for the configured read latency, and returns the read word with a one-cycle valid pulse. Fetch results are also latched into the instruction register.

## Interface
Parameters:
- `ADDR_W`, default 10: address width for `pc`, `rdest` and `mem_addr`.
- `DATA_W`, default 16: data width for write data, read data and `instr`.
- `READ_LAT`, default 1: RAM read latency in cycles. Legal range 1..4; any other value is an elaboration error.

Ports:
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block can accept a request.
- `req_fetch` in 1: 1 selects an instruction fetch from `pc`; 0 selects a data access from `rdest`.
- `req_write` in 1: 1 selects a store. Ignored when `req_fetch`=1.
- `pc` in ADDR_W: fetch address.
- `rdest` in ADDR_W: data address.
- `wdata` in DATA_W: store data.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_data` out DATA_W: read word. Holds 0 after a store.
- `rsp_fetch` out 1: the completing request was a fetch.
- `instr` out DATA_W: instruction register.
- `mem_addr` out ADDR_W: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- Handshake: a request is accepted in a cycle where `req_valid`=1 and `req_ready`=1.
  - `req_ready` = (state==IDLE) and `rst_n`=1.
  - `req_valid` in any other state is ignored and is not queued.
- On accept, the block registers:
  - address: `pc` if `req_fetch`=1, else `rdest`;
  - `wdata`;
  - the operation: fetch, load or store. `req_fetch`=1 with `req_write`=1 is treated as a fetch.
- Inputs are sampled only on the accept edge. Changes after accept have no effect.
- IDLE → ISSUE on accept.
- ISSUE:
  - `mem_addr` = registered address.
  - `mem_we`=1 for a store only, for exactly this one cycle.
  - Store: ISSUE → RESP.
  - Load or fetch: ISSUE → WAIT, loading the latency counter with READ_LAT−1.
- WAIT:
  - `mem_addr` is held.
  - The counter decrements each cycle.
  - When the counter is 0, capture `mem_rdata` into `rsp_data` and go to RESP.
  - A fetch also loads `instr` on that same edge.
- RESP:
  - `rsp_valid`=1 for one cycle, then go to IDLE.
  - There is no response backpressure; the consumer must take the data in the pulse cycle.
- `rsp_data` holds its value until the next completion. A store completion writes 0 to it.
- `instr` changes only on fetch completion.
- `mem_addr` and `mem_wdata` hold their last registered values in IDLE. `mem_we`=0 in every state except ISSUE.
- Reset values: state IDLE; `rsp_valid`, `rsp_data`, `rsp_fetch`, `instr`, `mem_addr`, `mem_wdata`, `mem_we` all 0; counter 0.
- Reset mid-operation: the in-flight request is abandoned.
  - `mem_we` drops immediately, asynchronously.
  - No `rsp_valid` is produced for the abandoned request.
  - `instr` is cleared.
- Address wrap: none. The full ADDR_W range is passed through unchanged.

## Timing
- Cycle 0 is the accept cycle. `rsp_valid` arrives:
  - Store: cycle 2.
  - Load or fetch: cycle READ_LAT+2. The data is visible together with `rsp_valid`.
- `req_ready` returns high in the cycle after RESP.
- Sustained throughput:
  - one store per 3 cycles;
  - one read per READ_LAT+3 cycles.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` or `mem_rdata` to any output.

## Structure
- Shared package `mem_port_pkg` contains:
  - the state encoding (2-bit enum: IDLE, ISSUE, WAIT, RESP);
  - the operation encoding (FETCH, LOAD, STORE);
  - default ADDR_W and DATA_W constants for reuse by the control FSM.
- No sub-module. The FSM, counter and datapath registers live in one module, and address selection is done inline at accept.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles → all outputs 0 and `req_ready`=0; release → `req_ready`=1 and state IDLE.
- Fetch, READ_LAT=1: pc=0x005 with RAM[5]=0xA123 → `mem_addr`=0x005 in cycle 1; `rsp_valid` with `rsp_data`=0xA123 and `rsp_fetch`=1 in cycle 3; `instr`=0xA123.
- Store then load: rdest=0x3FF, wdata=0xBEEF, write → `mem_we`=1 only in cycle 1 and `rsp_valid` in cycle 2 with data 0. A following load from 0x3FF returns 0xBEEF and `instr` is unchanged.
- READ_LAT=3 load: accept in cycle 0 → `rsp_valid` in cycle 5. A `req_valid` pulsed during cycles 1–5 is ignored; `req_ready`=1 again in cycle 6.
- Reset mid-operation: assert `rst_n`=0 during ISSUE of a store → `mem_we` falls without waiting for a clock edge; no `rsp_valid` is ever seen; RAM contents at the target address are unchanged if reset precedes the write edge.
- Fetch with `req_write`=1 and rdest≠pc → read from pc, `mem_we` never asserts.
